// File: rtl/mccoy_pkg.sv
// Shared opcodes, MUL state type and ALU helpers for the McCoy accumulator core.
// Helpers work on MAXW-bit vectors with an explicit active width, so DATA_W must stay below MAXW.
package mccoy_pkg;

   localparam int MAXW = 32;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LI  = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SR  = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic {ST_IDLE, ST_RUN} mul_state_t;

   // Returns {result, carry, overflow}. SUB is a + ~b + 1, so carry means no borrow.
   function automatic logic [MAXW+1:0] sat_add(input logic [MAXW-1:0] a,
                                                input logic [MAXW-1:0] b,
                                                input logic            sub,
                                                input logic            sat,
                                                input int unsigned     w);
      logic [MAXW-1:0] mask;
      logic [MAXW-1:0] msb;
      logic [MAXW-1:0] bb;
      logic [MAXW-1:0] res;
      logic [MAXW:0]   sum;
      logic            sa;
      logic            sb;
      logic            sr;
      logic            c;
      logic            v;
      mask = {MAXW{1'b1}} >> (MAXW - w);
      msb  = mask ^ (mask >> 1);
      bb   = (sub ? ~b : b) & mask;
      sum  = {1'b0, a & mask} + {1'b0, bb} + {{MAXW{1'b0}}, sub};
      res  = sum[MAXW-1:0] & mask;
      c    = |(sum >> w);
      sa   = |(a & msb);
      sb   = |(bb & msb);
      sr   = |(res & msb);
      v    = (sa == sb) && (sr != sa);
      if (sat && v)
         res = sa ? msb : (mask >> 1);
      return {res, c, v};
   endfunction

   function automatic logic [MAXW-1:0] sext_imm(input logic [MAXW-1:0] imm,
                                                 input int unsigned     iw);
      logic [MAXW-1:0] mask;
      logic [MAXW-1:0] msb;
      mask = {MAXW{1'b1}} >> (MAXW - iw);
      msb  = mask ^ (mask >> 1);
      return (|(imm & msb)) ? (imm | ~mask) : (imm & mask);
   endfunction

endpackage

// File: rtl/mccoy_seq_mul.sv
// Shift-add multiplier: one partial-product step per cycle, W steps, low W bits of the product.
//
// state   | meaning
// ST_IDLE | waiting for start; operands latched on start
// ST_RUN  | one shift-add step per cycle; done pulses on the last step
module mccoy_seq_mul
   import mccoy_pkg::*;
#(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] p
);

   localparam int CW = $clog2(W);

   mul_state_t    state;
   mul_state_t    state_nxt;
   logic [W-1:0]  mcand;
   logic [W-1:0]  mplier;
   logic [W-1:0]  prod;
   logic [W-1:0]  prod_step;
   logic [CW-1:0] cnt;
   logic          last;

   assign prod_step = mplier[0] ? prod + mcand : prod;
   assign last      = (cnt == CW'(W - 1));
   // Final product is presented combinationally so the accumulator takes it on the last step edge.
   assign p         = prod_step;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start)
               state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last) begin
               done      = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start) begin
            mcand  <= a;
            mplier <= b;
            prod   <= '0;
            cnt    <= '0;
         end else if (state == ST_RUN) begin
            prod   <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/mccoy_acc_core.sv
// McCoy accumulator core: register file, accumulator, Z/C/V flags, valid/ready handshake
// and single-cycle ALU, with MUL delegated to the sequential shift-add engine.
module mccoy_acc_core
   import mccoy_pkg::*;
#(
   parameter int DATA_W   = 6,
   parameter int IMM_W    = 3,
   parameter int OP_W     = 3,
   parameter int NREGS    = 8,
   parameter int SATURATE = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  instr_valid,
   input  logic [IMM_W+OP_W-1:0] instr,
   output logic                  instr_ready,
   output logic [DATA_W-1:0]     acc_out,
   output logic                  flag_z,
   output logic                  flag_c,
   output logic                  flag_v,
   output logic                  busy
);

   logic [OP_W-1:0]   opcode;
   logic [IMM_W-1:0]  operand;
   logic [DATA_W-1:0] regs [2**IMM_W];
   logic [DATA_W-1:0] acc;
   logic [DATA_W-1:0] acc_nxt;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] imm_val;
   logic [DATA_W-1:0] arith_val;
   logic [DATA_W-1:0] mul_p;
   logic [MAXW+1:0]   arith;
   logic [MAXW-1:0]   imm_ext;
   logic              z_nxt;
   logic              c_nxt;
   logic              v_nxt;
   logic              acc_we;
   logic              reg_we;
   logic              idx_ok;
   logic              accept;
   logic              mul_start;
   logic              mul_done;
   logic              mul_busy;
   logic              unused_hi;

   assign {operand, opcode} = instr;

   // x0 and indices past NREGS read as zero and are never written.
   assign idx_ok = (operand != '0) && (32'(operand) < NREGS);
   assign rdata  = idx_ok ? regs[operand] : '0;

   assign instr_ready = ~mul_busy;
   assign busy        = mul_busy;
   assign accept      = instr_valid & instr_ready;
   assign mul_start   = accept && (opcode == OP_MUL);
   assign acc_out     = acc;

   assign imm_ext   = sext_imm(MAXW'(operand), IMM_W);
   assign imm_val   = imm_ext[DATA_W-1:0];
   assign arith     = sat_add(MAXW'(acc), MAXW'(rdata), opcode == OP_SUB, SATURATE != 0, DATA_W);
   assign arith_val = arith[DATA_W+1:2];
   assign unused_hi = ^{arith[MAXW+1:DATA_W+2], imm_ext[MAXW-1:DATA_W]};

   mccoy_seq_mul #(.W(DATA_W)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .a       (acc),
      .b       (rdata),
      .busy    (mul_busy),
      .done    (mul_done),
      .p       (mul_p)
   );

   always_comb begin
      acc_nxt = acc;
      acc_we  = 1'b0;
      c_nxt   = flag_c;
      v_nxt   = flag_v;
      reg_we  = 1'b0;
      // MUL completion and an accept never share an edge since instr_ready is low while running.
      if (mul_done) begin
         acc_nxt = mul_p;
         acc_we  = 1'b1;
         c_nxt   = 1'b0;
         v_nxt   = 1'b0;
      end else if (accept) begin
         case (opcode)
            OP_LI: begin
               acc_nxt = imm_val;
               acc_we  = 1'b1;
            end
            OP_SUB, OP_ADD: begin
               acc_nxt = arith_val;
               acc_we  = 1'b1;
               c_nxt   = arith[1];
               v_nxt   = arith[0];
            end
            OP_XOR: begin
               acc_nxt = acc ^ rdata;
               acc_we  = 1'b1;
               c_nxt   = 1'b0;
               v_nxt   = 1'b0;
            end
            OP_SR: reg_we = idx_ok;
            OP_NOT: begin
               acc_nxt = ~acc;
               acc_we  = 1'b1;
               c_nxt   = 1'b0;
               v_nxt   = 1'b0;
            end
            default: ;
         endcase
      end
      z_nxt = acc_we ? (acc_nxt == '0) : flag_z;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
         for (int i = 0; i < 2**IMM_W; i++)
            regs[i] <= '0;
      end else begin
         acc    <= acc_nxt;
         flag_z <= z_nxt;
         flag_c <= c_nxt;
         flag_v <= v_nxt;
         if (reg_we)
            regs[operand] <= acc;
      end
   end

endmodule

// File: doc/mccoy_acc_core.md
Name: mccoy_acc_core

Overview:
Parametrised next-generation McCoy accumulator core. It is a single-accumulator, small-register-file datapath driven by a packed instruction word of the form {operand, opcode}. Relative to the first-generation McCoy, it adds:
- generic data width and register count
- a valid/ready instruction handshake
- SUB and XOR ops
- Z/C/V flags
- an optional saturating add/sub mode
- a multi-cycle sequential MUL with a busy interlock

It sits behind the TinyTapeout io wrapper, which packs instr/valid onto io_in and acc_out onto io_out.

Parameters:
DATA_W, 6, accumulator, register and ALU width (>=4).
IMM_W, 3, operand field width; also the register index width.
OP_W, 3, opcode field width (fixed encoding below; must be 3).
NREGS, 8, register count, x0..x(NREGS-1), NREGS <= 2**IMM_W.
SATURATE, 0, 1 = ADD/SUB clamp to signed max/min on overflow.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present this cycle
instr  in  IMM_W+OP_W  {operand[IMM_W-1:0], opcode[OP_W-1:0]}
instr_ready  out  1  core can accept an instruction; equals ~busy
acc_out  out  DATA_W  accumulator, registered
flag_z  out  1  acc == 0 after the last acc write
flag_c  out  1  ADD carry-out / SUB no-borrow
flag_v  out  1  signed overflow of the last ADD/SUB (pre-saturation)
busy  out  1  MUL in progress

Behaviour:
- Reset (async assert, sync release): acc, all registers, flags, busy, FSM and counters all go to 0. instr_ready = 1.
- Accept: an instruction is accepted on a clk edge when instr_valid & instr_ready. Otherwise it is ignored, with no state change.
- Latency: single-cycle ops update acc, flags and registers at the accepting edge. Results are visible on outputs right after that edge.
- Operand semantics: imm = sign-extended operand field. r = operand field used as a register index. Indices >= NREGS read 0, and SR to them is a no-op.
- x0 reads 0 always. SR x0 is a no-op.
- Opcodes:
  - 000 NOP: nothing changes.
  - 001 LI: acc <= sext(imm). Updates Z; C and V are unchanged.
  - 010 SUB: acc <= acc - x[r]. Updates Z, C (1 = no borrow) and V.
  - 011 ADD: acc <= acc + x[r]. Updates Z, C and V.
  - 100 MUL: multi-cycle; see below.
  - 101 XOR: acc <= acc ^ x[r]. Updates Z; clears C and V.
  - 110 SR: x[r] <= acc. Flags are unchanged.
  - 111 NOT: acc <= ~acc; the operand is ignored. Updates Z; clears C and V.
- Saturation (SATURATE=1):
  - On signed overflow, acc <= 0111..1 if the true result is positive, else 1000..0.
  - V still reports the overflow.
  - Z is computed on the clamped value.
- Wrap mode (SATURATE=0): two's-complement wrap.
- MUL FSM, states IDLE and RUN:
  - IDLE -> RUN on accepting MUL. At that edge: latch mcand <= acc, mplier <= x[r], prod <= 0, cnt <= 0, and busy <= 1.
  - RUN performs one shift-add step per cycle: if mplier[0], prod += mcand; then mcand <<= 1, mplier >>= 1, cnt++. All of this is DATA_W bits wide (low half only, which is valid for signed operands).
  - On the edge where cnt == DATA_W-1 completes its step: acc <= final prod, Z updated, C and V cleared, busy <= 0, FSM -> IDLE.
  - busy is high for exactly DATA_W cycles. The next instruction can be accepted on the edge following the acc update.
  - Instructions presented during RUN are ignored (instr_ready = 0). The bench must see no acc, register or flag change from them.
- Reset mid-MUL: immediate return to the reset state. The partial product is discarded.
- Simultaneous events: none are possible. At most one instruction is accepted per edge, and MUL completion never coincides with an accept.

Decomposition:
- mccoy_pkg:
  - opcode localparams OP_NOP..OP_NOT
  - the state type {ST_IDLE, ST_RUN}
  - helper functions sat_add(a, b, sub, sat) -> {result, c, v}, and sext_imm
- Sub-module mccoy_seq_mul, the shift-add engine:
  - inputs: clk, reset_n, start, a, b
  - outputs: busy, done (1-cycle pulse), p
- The top module holds the register file, accumulator, flags, handshake and ALU, and instantiates mccoy_seq_mul.

Test Plan:
1. Reset then release -> acc_out=0, Z=C=V=0, busy=0, instr_ready=1. Assert reset_n low mid-test -> outputs return to 0 asynchronously, before the next edge.
2. Sequence LI 3, SR x2, LI -4, SR x3, LI 2, ADD x2 -> acc=5. Then LI 2, ADD x3 -> acc=-2 (6'h3E), Z=0, V=0.
3. Overflow: LI 3, SR x1, then repeat ADD x1 / SR x1 up to 24, then ADD x1:
   - SATURATE=0 -> acc=-16 (6'h30), V=1.
   - SATURATE=1 -> acc=31 (6'h1F), V=1.
4. LI 3, SR x1, SUB x1 -> acc=0, Z=1, C=1, V=0. Then LI 0, SUB x1 -> acc=-3, C=0.
5. MUL: LI -3, SR x2, LI 3, MUL x2 -> busy=1 for 6 cycles and instr_ready=0. A valid LI 1 during busy is ignored. After completion acc=-9 (6'h37) and busy=0. An instruction issued right after is accepted.
6. Edge ops: SR x0 then ADD x0 -> acc unchanged. NOT on 12 -> -13. XOR of a value with itself -> Z=1. instr_valid=0 on an LI 2 word -> no change.
